// File: rtl/div_hilo_stage_pkg.sv
// div_hilo_stage_pkg: shared state encoding and constants for the HI/LO divide stage
package div_hilo_stage_pkg;
    localparam int DIV_WIDTH = 32;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;
    typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_t;
endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: conditional two's-complement negate
//   value  - input operand
//   negate - 1 = output -value, 0 = pass value through
//   result - WIDTH-bit result (wraps, so -MIN == MIN)
module div_sign_fix import div_hilo_stage_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);
    assign result = negate ? -value : value;
endmodule

// File: rtl/div_hilo_stage.sv
// div_hilo_stage: multi-cycle DIV/DIVU control around an external combinational unsigned divider
//   clock, clear_n        - clock, async active-low reset
//   start, signed_op      - request and signedness, sampled in IDLE
//   dividend, divisor     - operands, sampled with start
//   div_a, div_b          - registered magnitudes to the divider
//   div_q, div_r          - unsigned quotient/remainder from the divider
//   busy, done            - not-IDLE status, one-cycle result pulse
//   div_by_zero           - last completed op had a zero divisor
//   hi_out, lo_out        - remainder (HI) and quotient (LO) registers
module div_hilo_stage import div_hilo_stage_pkg::*; #(
    parameter int WIDTH         = DIV_WIDTH,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    state_t state, state_d;
    logic [3:0] cnt;
    logic neg_a, neg_b, sign_q, sign_r, zero;
    logic [WIDTH-1:0] raw_a, mag_a, mag_b, fix_q, fix_r;
    logic accept;

    assign neg_a  = signed_op & dividend[WIDTH-1];
    assign neg_b  = signed_op & divisor[WIDTH-1];
    assign accept = state == IDLE && start;
    assign busy   = state != IDLE;

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_a (.value(dividend), .negate(neg_a),  .result(mag_a));
    div_sign_fix #(.WIDTH(WIDTH)) u_fix_b (.value(divisor),  .negate(neg_b),  .result(mag_b));
    div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (.value(div_q),    .negate(sign_q), .result(fix_q));
    div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (.value(div_r),    .negate(sign_r), .result(fix_r));

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) state <= IDLE;
        else          state <= state_d;
    end

    // a zero divisor skips WAIT so the divider never sees div_b == 0 while settling
    always_comb begin
        state_d = IDLE;
        state_d = state == IDLE ? (start ? (divisor == '0 ? WRITE : WAIT) : IDLE) :
                  state == WAIT ? (cnt == '0 ? WRITE : WAIT) : IDLE;
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            cnt         <= '0;
            div_a       <= '0;
            div_b       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            zero        <= 1'b0;
            raw_a       <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi_out      <= '0;
            lo_out      <= '0;
        end else begin
            done <= state == WRITE;
            if (accept) begin
                div_a  <= mag_a;
                div_b  <= mag_b;
                sign_q <= neg_a ^ neg_b;
                sign_r <= neg_a;
                raw_a  <= dividend;
                zero   <= divisor == '0;
                cnt    <= 4'(SETTLE_CYCLES - 1);
            end
            if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
            if (state == WRITE) begin
                lo_out      <= zero ? WIDTH'(DIV_ZERO_QUOT) : fix_q;
                hi_out      <= zero ? raw_a : fix_r;
                div_by_zero <= zero;
            end
        end
    end
endmodule

// File: tb/tb_div_hilo_stage.sv
// tb_div_hilo_stage: randomized self-checking bench for div_hilo_stage against an arithmetic reference
module tb_div_hilo_stage;
    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] div_a, div_b, div_q, div_r, hi_out, lo_out;
    logic        busy, done, div_by_zero;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    // stand-in for the team's combinational unsigned divider
    assign div_q = (div_b == '0) ? '1 : div_a / div_b;
    assign div_r = (div_b == '0) ? div_a : div_a % div_b;

    div_hilo_stage #(.WIDTH(32), .SETTLE_CYCLES(SETTLE)) dut (
        .clock(clk), .clear_n(clear_n), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .div_a(div_a), .div_b(div_b),
        .div_q(div_q), .div_r(div_r), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi_out(hi_out), .lo_out(lo_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mag(input logic s, input logic [31:0] v);
        longint sv = s ? longint'($signed(v)) : longint'(v);
        return 32'(sv < 0 ? -sv : sv);
    endfunction

    function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b, input bit poke);
        logic [31:0] eq, er;
        int cycles = 0;
        bit got = 0;
        ref_div(s, a, b, eq, er);
        @(negedge clk);
        start = 1'b1; signed_op = s; dividend = a; divisor = b;
        @(posedge clk); #1;
        check("busy_edge0", 32'(busy), 32'd1);
        if (b != 0) begin
            check("div_a", div_a, mag(s, a));
            check("div_b", div_b, mag(s, b));
        end
        start = poke;
        if (poke) begin signed_op = 1'b0; dividend = 32'd1; divisor = 32'd1; end
        while (!got && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
            start = 1'b0;
            got = done;
            if (!got && b != 0) check("div_b_nonzero", 32'(div_b != 0), 32'd1);
        end
        check("latency", 32'(cycles), b == 0 ? 32'd1 : 32'(SETTLE + 1));
        check("lo_out", lo_out, eq);
        check("hi_out", hi_out, er);
        check("div_by_zero", 32'(div_by_zero), 32'(b == 0));
        check("busy_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int dones;
        logic s;
        logic [31:0] a, b;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        check("rst_div_a", div_a, 32'd0);
        check("rst_div_b", div_b, 32'd0);
        clear_n = 1'b1;

        run_op(1'b0, 32'd100, 32'd7, 1'b0);
        run_op(1'b1, -32'sd7, 32'd2, 1'b0);
        run_op(1'b1, 32'd7, -32'sd2, 1'b0);
        run_op(1'b1, -32'sd7, -32'sd2, 1'b0);
        run_op(1'b0, 32'd5, 32'd0, 1'b0);
        run_op(1'b0, 32'd9, 32'd3, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'h10, 1'b0);
        run_op(1'b0, 32'd20, 32'd3, 1'b1);
        check("done_cycle", 32'(done), 32'd1);
        run_op(1'b0, 32'd9, 32'd4, 1'b0);

        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; dividend = 32'd50; divisor = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        clear_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_hi", hi_out, 32'd0);
        check("rst_mid_lo", lo_out, 32'd0);
        @(negedge clk);
        clear_n = 1'b1;
        dones = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("no_done_after_rst", 32'(dones), 32'd0);
        run_op(1'b0, 32'd8, 32'd2, 1'b0);

        for (int i = 0; i < 150; i++) begin
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000;
                1: a = $urandom_range(0, 100);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'h8000_0000;
                3: b = $urandom_range(1, 16);
                default: b = $urandom;
            endcase
            run_op(s, a, b, $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/div_hilo_stage.md
Name: div_hilo_stage

Overview:
Multi-cycle control stage wrapped around the team's combinational 32-bit unsigned magnitude divider. It serves the DIV/DIVU path of the datapath.
- Upstream side: latches operands on a start strobe, converts signed operands to magnitudes and drives the divider.
- Downstream side: waits a fixed settle time, captures quotient and remainder, applies sign correction and writes the HI/LO result registers with a done pulse.
- Handles divide-by-zero and the signed overflow case deterministically.

Parameters:
WIDTH, 32, operand/result width
SETTLE_CYCLES, 2, clock edges allowed for the combinational divider to settle; legal range 1..15

Ports:
clock  in  1  rising-edge clock
clear_n  in  1  asynchronous active-low reset
start  in  1  request a divide; sampled only in IDLE
signed_op  in  1  1 = signed DIV, 0 = unsigned DIVU; sampled with start
dividend  in  WIDTH  dividend operand, sampled with start
divisor  in  WIDTH  divisor operand, sampled with start
div_a  out  WIDTH  magnitude dividend to the divider (registered)
div_b  out  WIDTH  magnitude divisor to the divider (registered)
div_q  in  WIDTH  unsigned quotient from the divider
div_r  in  WIDTH  unsigned remainder from the divider
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when hi_out/lo_out are updated
div_by_zero  out  1  status of the last completed operation; 1 if its divisor was 0
hi_out  out  WIDTH  remainder register (HI)
lo_out  out  WIDTH  quotient register (LO)

Behaviour:
- Clock and reset: one clock, `clock`. `clear_n` is asynchronous and active-low. While low, all state resets:
  - FSM goes to IDLE and the settle counter clears.
  - busy=0, done=0, div_by_zero=0.
  - hi_out=0, lo_out=0, div_a=0, div_b=0, sign flags cleared.
- Reset mid-operation abandons the operation. No done pulse follows and hi_out/lo_out read 0.
- FSM states: IDLE, WAIT, WRITE.
- IDLE, start=1 at an edge:
  - Sign flags: neg_a = signed_op & dividend[WIDTH-1]; neg_b = signed_op & divisor[WIDTH-1].
  - div_a = neg_a ? -dividend : dividend; div_b = neg_b ? -divisor : divisor (two's complement, WIDTH bits).
  - Latch sign_q = neg_a ^ neg_b, sign_r = neg_a, and the raw dividend.
  - If divisor == 0: go to WRITE with the zero flag set.
  - Otherwise: go to WAIT with cnt = SETTLE_CYCLES-1.
- WAIT:
  - Each edge: if cnt != 0, decrement; if cnt == 0, go to WRITE.
  - div_a/div_b stay stable throughout WAIT.
- WRITE (a single edge) then returns to IDLE:
  - Normal case: lo_out = sign_q ? -div_q : div_q; hi_out = sign_r ? -div_r : div_r.
  - Zero case: lo_out = all ones; hi_out = raw latched dividend; div_by_zero = 1.
  - Normal case clears div_by_zero.
  - done is 1 for exactly the cycle following the WRITE edge.
- Latency, counting the edge that samples start as edge 0:
  - Normal divide: hi_out/lo_out update and done rises after edge SETTLE_CYCLES+1.
  - Divide-by-zero: hi_out/lo_out update and done rises after edge 1.
- Signed semantics: truncation toward zero; the remainder takes the sign of the dividend.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo_out = 0x80000000, hi_out = 0. This is natural wrap with no flag.
- Divider contract: div_b is never 0 while in WAIT. div_a/div_b may be 0x80000000 (magnitude of the most negative value).
- start while busy: ignored, with no queuing. Operand inputs are don't-care except on the start edge.
- start in the IDLE cycle that shows done=1: accepted as a new operation (back-to-back allowed).
- hi_out/lo_out hold their value between operations.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, WAIT, WRITE).
  - Constant DIV_ZERO_QUOT = all ones.
  - WIDTH default.
- One natural sub-module: div_sign_fix, a combinational conditional two's-complement negate (input value, negate flag, output). It is instantiated four times: dividend magnitude, divisor magnitude, quotient fix, remainder fix.
- The divider itself stays external and is connected by the parent datapath.

Test Plan:
- Bench setup: bench connects div_a/div_b/div_q/div_r to the team's unsigned divider; SETTLE_CYCLES=2 for all scenarios.
- Unsigned: signed_op=0, 100/7 -> done at edge 3, lo_out=14, hi_out=2, div_by_zero=0, busy high for edges 0..2.
- Signed sign matrix (signed_op=1):
  - -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 7/-2 -> lo=0xFFFFFFFD, hi=1.
  - -7/-2 -> lo=3, hi=0xFFFFFFFF.
- Corner values:
  - 5/0 -> done at edge 1, lo=0xFFFFFFFF, hi=5, div_by_zero=1; a following 9/3 -> lo=3, hi=0, div_by_zero=0.
  - signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU 0xFFFFFFFF/0x10 -> lo=0x0FFFFFFF, hi=0xF.
- Handshake: pulse start with 20/3, then again at edge 1 with 1/1 -> second start ignored; result lo=6, hi=2. start in the done cycle with 9/4 -> accepted, lo=2, hi=1.
- Reset: drop clear_n in WAIT of 50/5 -> immediately busy=0, hi/lo=0. No done after release; next 8/2 -> lo=4, hi=0.
